// File: rtl/ntt_pair_addr_gen.sv
// ntt_pair_addr_gen
//    Butterfly pair sequencer for a radix-2 NTT/INTT core. Walks all LOG_N
//    stages of a length-N transform and presents, for every butterfly, the two
//    coefficient RAM addresses and the twiddle ROM address on a valid/ready
//    handshake. Stage ordering is Cooley-Tukey for NTT, Gentleman-Sande for INTT.
//
//    Optional feature macro: STAGE_DRAIN_EN
//       When defined, DRAIN_CYCLES idle cycles are inserted between stages so
//       the downstream butterfly/RAM pipeline can retire its writes before the
//       next stage reads them. No drain follows the final stage.
//
//    Ports
//       i_clk        rising-edge clock
//       i_rst        synchronous active-high reset (aborts without a done pulse)
//       i_start      start a transform (only sampled while idle)
//       i_select     0 = NTT, 1 = INTT (latched on accepted start)
//       i_out_ready  downstream accepts the current pair
//       o_out_valid  pair outputs valid
//       o_addr_1     first operand address
//       o_addr_2     second operand address
//       o_tw_addr    twiddle ROM address
//       o_stage      current stage index
//       o_busy       high whenever not idle
//       o_done       one-cycle pulse after the last transfer
module ntt_pair_addr_gen #(
   parameter int LOG_N        = 8,
   parameter int DRAIN_CYCLES = 4
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_start,
   input  logic             i_select,
   input  logic             i_out_ready,
   output logic             o_out_valid,
   output logic [LOG_N-1:0] o_addr_1,
   output logic [LOG_N-1:0] o_addr_2,
   output logic [LOG_N-1:0] o_tw_addr,
   output logic [LOG_N-1:0] o_stage,
   output logic             o_busy,
   output logic             o_done
);

   localparam int PW = LOG_N - 1;
   localparam logic [LOG_N-1:0] LAST_S     = LOG_N'(LOG_N - 1);
   localparam logic [PW-1:0]    LAST_P     = {PW{1'b1}};
   localparam logic [LOG_N-1:0] S_ONE      = {{(LOG_N-1){1'b0}}, 1'b1};
   localparam logic [PW-1:0]    P_ONE      = {{(PW-1){1'b0}}, 1'b1};
   localparam logic [7:0]       DRAIN_LOAD = 8'(DRAIN_CYCLES - 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   // Pair address generation. With k = log2(h) (LOG_N-1-s for NTT, s for INTT)
   // both orderings reduce to: addr_1 = p with a zero inserted at bit k,
   // addr_2 = addr_1 | h, tw = (1 << (LOG_N-1-k)) + (p >> k).
   function automatic logic [3*LOG_N-1:0] pair_addr(
      input logic [LOG_N-1:0] s,
      input logic [PW-1:0]    p,
      input logic             sel
   );
      logic [LOG_N-1:0] k;
      logic [LOG_N-1:0] pe;
      logic [LOG_N-1:0] lo_mask;
      logic [LOG_N-1:0] a1;
      logic [LOG_N-1:0] tw;
      k       = sel ? s : (LAST_S - s);
      pe      = {1'b0, p};
      lo_mask = (S_ONE << k) - S_ONE;
      a1      = ((pe & ~lo_mask) << 1) | (pe & lo_mask);
      tw      = (S_ONE << (LAST_S - k)) + (pe >> k);
      return {a1, a1 | (S_ONE << k), tw};
   endfunction

   state_t             r_state;
   state_t             w_state_nxt;
   logic [LOG_N-1:0]   r_s;
   logic [LOG_N-1:0]   w_s_nxt;
   logic [PW-1:0]      r_p;
   logic [PW-1:0]      w_p_nxt;
   logic               r_sel;
   logic               w_sel_nxt;
   logic               w_xfer;
   logic [3*LOG_N-1:0] w_pair;
   logic               w_valid_nxt;
   logic               w_busy_nxt;
   logic               w_done_nxt;
   logic [LOG_N-1:0]   w_addr_1_nxt;
   logic [LOG_N-1:0]   w_addr_2_nxt;
   logic [LOG_N-1:0]   w_tw_nxt;
   logic [LOG_N-1:0]   w_stage_nxt;

`ifdef STAGE_DRAIN_EN
   logic [7:0]         r_drain_cnt;
   logic [7:0]         w_drain_cnt_nxt;
`else
   logic [7:0]         w_unused_drain;
   assign w_unused_drain = DRAIN_LOAD;
`endif

   // out_valid is high exactly in RUN, so a transfer is RUN plus ready.
   assign w_xfer = (r_state == ST_RUN) && i_out_ready;

   // Next-state and counter logic.
   always_comb begin
      w_state_nxt = r_state;
      w_s_nxt     = r_s;
      w_p_nxt     = r_p;
      w_sel_nxt   = r_sel;
`ifdef STAGE_DRAIN_EN
      w_drain_cnt_nxt = r_drain_cnt;
`endif
      case (r_state)
         ST_IDLE: begin
            if (i_start) begin
               w_state_nxt = ST_RUN;
               w_s_nxt     = '0;
               w_p_nxt     = '0;
               w_sel_nxt   = i_select;
            end else begin
               w_state_nxt = ST_IDLE;
            end
         end
         ST_RUN: begin
            if (!w_xfer) begin
               w_state_nxt = ST_RUN;
            end else if (r_p != LAST_P) begin
               w_p_nxt = r_p + P_ONE;
            end else if (r_s != LAST_S) begin
`ifdef STAGE_DRAIN_EN
               w_state_nxt     = ST_DRAIN;
               w_drain_cnt_nxt = DRAIN_LOAD;
`else
               w_s_nxt = r_s + S_ONE;
               w_p_nxt = '0;
`endif
            end else begin
               w_state_nxt = ST_DONE;
            end
         end
         ST_DRAIN: begin
`ifdef STAGE_DRAIN_EN
            if (r_drain_cnt == 8'd0) begin
               w_state_nxt = ST_RUN;
               w_s_nxt     = r_s + S_ONE;
               w_p_nxt     = '0;
            end else begin
               w_drain_cnt_nxt = r_drain_cnt - 8'd1;
            end
`else
            w_state_nxt = ST_IDLE;
`endif
         end
         ST_DONE: begin
            w_state_nxt = ST_IDLE;
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // Output decode from the next state so every output leaves a flop.
   always_comb begin
      w_pair       = pair_addr(w_s_nxt, w_p_nxt, w_sel_nxt);
      w_valid_nxt  = (w_state_nxt == ST_RUN);
      w_busy_nxt   = (w_state_nxt != ST_IDLE);
      w_done_nxt   = (w_state_nxt == ST_DONE);
      if (w_valid_nxt) begin
         w_addr_1_nxt = w_pair[3*LOG_N-1:2*LOG_N];
         w_addr_2_nxt = w_pair[2*LOG_N-1:LOG_N];
         w_tw_nxt     = w_pair[LOG_N-1:0];
      end else begin
         w_addr_1_nxt = '0;
         w_addr_2_nxt = '0;
         w_tw_nxt     = '0;
      end
      if ((w_state_nxt == ST_RUN) || (w_state_nxt == ST_DRAIN)) begin
         w_stage_nxt = w_s_nxt;
      end else begin
         w_stage_nxt = '0;
      end
   end

   // State, counters and registered outputs.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state     <= ST_IDLE;
         r_s         <= '0;
         r_p         <= '0;
         r_sel       <= 1'b0;
         o_out_valid <= 1'b0;
         o_addr_1    <= '0;
         o_addr_2    <= '0;
         o_tw_addr   <= '0;
         o_stage     <= '0;
         o_busy      <= 1'b0;
         o_done      <= 1'b0;
`ifdef STAGE_DRAIN_EN
         r_drain_cnt <= 8'd0;
`endif
      end else begin
         r_state     <= w_state_nxt;
         r_s         <= w_s_nxt;
         r_p         <= w_p_nxt;
         r_sel       <= w_sel_nxt;
         o_out_valid <= w_valid_nxt;
         o_addr_1    <= w_addr_1_nxt;
         o_addr_2    <= w_addr_2_nxt;
         o_tw_addr   <= w_tw_nxt;
         o_stage     <= w_stage_nxt;
         o_busy      <= w_busy_nxt;
         o_done      <= w_done_nxt;
`ifdef STAGE_DRAIN_EN
         r_drain_cnt <= w_drain_cnt_nxt;
`endif
      end
   end

endmodule

// File: tb/tb_ntt_pair_addr_gen.sv
// tb_ntt_pair_addr_gen
//    Directed bench for ntt_pair_addr_gen at LOG_N=3 (N=8). Expected pair
//    sequences are hand-written tables of {addr_1, addr_2, tw_addr}.
module tb_ntt_pair_addr_gen;
   localparam int LOG_N = 3;
   localparam int DC    = 4;
`ifdef STAGE_DRAIN_EN
   localparam int GAP_EXP = DC;
`else
   localparam int GAP_EXP = 0;
`endif

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic       sel;
   logic       ready;
   logic       o_out_valid;
   logic [2:0] o_addr_1;
   logic [2:0] o_addr_2;
   logic [2:0] o_tw_addr;
   logic [2:0] o_stage;
   logic       o_busy;
   logic       o_done;

   int n_cmp = 0;
   int n_err = 0;

   logic [8:0] ntt_tab  [12];
   logic [8:0] intt_tab [12];

   ntt_pair_addr_gen #(.LOG_N(LOG_N), .DRAIN_CYCLES(DC)) dut (
      .i_clk       (clk),
      .i_rst       (rst),
      .i_start     (start),
      .i_select    (sel),
      .i_out_ready (ready),
      .o_out_valid (o_out_valid),
      .o_addr_1    (o_addr_1),
      .o_addr_2    (o_addr_2),
      .o_tw_addr   (o_tw_addr),
      .o_stage     (o_stage),
      .o_busy      (o_busy),
      .o_done      (o_done)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Runs one transform; mode 0 = ready always high, mode 1 = ready pattern 1,0,0,1.
   // pulse = toggle start while busy (must be ignored).
   task automatic run_xform(input logic s_in, input int mode, input bit pulse);
      logic [8:0] exp_v;
      logic [2:0] h1, h2, ht, hs;
      int         n = 0;
      int         done_cnt = 0;
      int         gap = 0;
      int         cyc = 0;
      bit         hold = 1'b0;
      bit         last_x = 1'b0;
      bit         fin = 1'b0;
      h1 = 3'd0; h2 = 3'd0; ht = 3'd0; hs = 3'd0;
      sel   = s_in;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      sel   = ~s_in;
      check_eq("first_valid", 32'(o_out_valid), 32'd1);
      check_eq("busy_run", 32'(o_busy), 32'd1);
      while (!fin && cyc < 300) begin
         if (hold) begin
            check_eq("hold_valid", 32'(o_out_valid), 32'd1);
            check_eq("hold_a1", 32'(o_addr_1), 32'(h1));
            check_eq("hold_a2", 32'(o_addr_2), 32'(h2));
            check_eq("hold_tw", 32'(o_tw_addr), 32'(ht));
            check_eq("hold_stage", 32'(o_stage), 32'(hs));
         end
         if (o_done) begin
            done_cnt++;
            check_eq("done_after_last", 32'(last_x), 32'd1);
            check_eq("xfer_count", 32'(n), 32'd12);
            fin = 1'b1;
            if (pulse) start = 1'b1;
         end else begin
            last_x = 1'b0;
            if (o_out_valid) begin
               ready = (mode == 0) ? 1'b1 : ((cyc % 4 == 0) || (cyc % 4 == 3));
               if (ready) begin
                  exp_v = s_in ? intt_tab[n % 12] : ntt_tab[n % 12];
                  check_eq("addr_1", 32'(o_addr_1), 32'(exp_v[8:6]));
                  check_eq("addr_2", 32'(o_addr_2), 32'(exp_v[5:3]));
                  check_eq("tw_addr", 32'(o_tw_addr), 32'(exp_v[2:0]));
                  check_eq("stage", 32'(o_stage), 32'((n % 12) / 4));
                  check_eq("gap", 32'(gap), 32'((n == 4 || n == 8) ? GAP_EXP : 0));
                  n++;
                  gap    = 0;
                  last_x = 1'b1;
                  hold   = 1'b0;
               end else begin
                  hold = 1'b1;
                  h1 = o_addr_1; h2 = o_addr_2; ht = o_tw_addr; hs = o_stage;
               end
            end else begin
               ready = 1'b1;
               hold  = 1'b0;
               gap++;
               check_eq("busy_gap", 32'(o_busy), 32'd1);
            end
            if (pulse) start = (cyc % 3 == 1);
         end
         cyc++;
         @(posedge clk); #1;
      end
      start = 1'b0;
      check_eq("done_seen", 32'(done_cnt), 32'd1);
      check_eq("done_pulse", 32'(o_done), 32'd0);
      check_eq("idle_busy", 32'(o_busy), 32'd0);
      @(posedge clk); #1;
      check_eq("stay_idle", 32'(o_busy), 32'd0);
      check_eq("stay_idle_v", 32'(o_out_valid), 32'd0);
   endtask

   initial begin
      int cnt;
      ntt_tab[0]  = {3'd0, 3'd4, 3'd1}; ntt_tab[1]  = {3'd1, 3'd5, 3'd1};
      ntt_tab[2]  = {3'd2, 3'd6, 3'd1}; ntt_tab[3]  = {3'd3, 3'd7, 3'd1};
      ntt_tab[4]  = {3'd0, 3'd2, 3'd2}; ntt_tab[5]  = {3'd1, 3'd3, 3'd2};
      ntt_tab[6]  = {3'd4, 3'd6, 3'd3}; ntt_tab[7]  = {3'd5, 3'd7, 3'd3};
      ntt_tab[8]  = {3'd0, 3'd1, 3'd4}; ntt_tab[9]  = {3'd2, 3'd3, 3'd5};
      ntt_tab[10] = {3'd4, 3'd5, 3'd6}; ntt_tab[11] = {3'd6, 3'd7, 3'd7};
      intt_tab[0]  = {3'd0, 3'd1, 3'd4}; intt_tab[1]  = {3'd2, 3'd3, 3'd5};
      intt_tab[2]  = {3'd4, 3'd5, 3'd6}; intt_tab[3]  = {3'd6, 3'd7, 3'd7};
      intt_tab[4]  = {3'd0, 3'd2, 3'd2}; intt_tab[5]  = {3'd1, 3'd3, 3'd2};
      intt_tab[6]  = {3'd4, 3'd6, 3'd3}; intt_tab[7]  = {3'd5, 3'd7, 3'd3};
      intt_tab[8]  = {3'd0, 3'd4, 3'd1}; intt_tab[9]  = {3'd1, 3'd5, 3'd1};
      intt_tab[10] = {3'd2, 3'd6, 3'd1}; intt_tab[11] = {3'd3, 3'd7, 3'd1};

      rst = 1'b1; start = 1'b0; sel = 1'b0; ready = 1'b0;
      @(posedge clk); @(posedge clk); #1;
      check_eq("rst_valid", 32'(o_out_valid), 32'd0);
      check_eq("rst_busy", 32'(o_busy), 32'd0);
      check_eq("rst_done", 32'(o_done), 32'd0);
      check_eq("rst_a1", 32'(o_addr_1), 32'd0);
      check_eq("rst_tw", 32'(o_tw_addr), 32'd0);
      rst = 1'b0;
      @(posedge clk); #1;

      run_xform(1'b0, 0, 1'b0);   // NTT, full throughput
      run_xform(1'b1, 0, 1'b0);   // INTT, full throughput
      run_xform(1'b0, 1, 1'b0);   // NTT with backpressure
      run_xform(1'b1, 1, 1'b0);   // INTT with backpressure
      run_xform(1'b0, 0, 1'b1);   // start pulses while busy

      // Abort mid-stage at s=1, p=2.
      sel = 1'b0; ready = 1'b1; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      cnt = 0;
      for (int c = 0; c < 50; c++) begin
         if (o_out_valid) begin
            if (cnt == 6) break;
            cnt++;
         end
         @(posedge clk); #1;
      end
      check_eq("mid_stage", 32'(o_stage), 32'd1);
      check_eq("mid_a1", 32'(o_addr_1), 32'd4);
      check_eq("mid_tw", 32'(o_tw_addr), 32'd3);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check_eq("abort_valid", 32'(o_out_valid), 32'd0);
      check_eq("abort_a1", 32'(o_addr_1), 32'd0);
      check_eq("abort_a2", 32'(o_addr_2), 32'd0);
      check_eq("abort_tw", 32'(o_tw_addr), 32'd0);
      check_eq("abort_stage", 32'(o_stage), 32'd0);
      check_eq("abort_busy", 32'(o_busy), 32'd0);
      for (int c = 0; c < 3; c++) begin
         check_eq("abort_no_done", 32'(o_done), 32'd0);
         @(posedge clk); #1;
      end
      run_xform(1'b0, 0, 1'b0);   // fresh start after abort

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
